// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one fixed-latency 64-bit ALU among NREQ requesters,
// with in-order responses through a credit-protected FIFO. Optional macro: ALU_ARB_PRIO0_EN.
module alu_arbiter #(
    parameter  int unsigned NREQ      = 4,
    parameter  int unsigned ALU_LAT   = 2,
    parameter  int unsigned RSP_DEPTH = 4,
    localparam int unsigned IDW       = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [4*NREQ-1:0]    req_op,
    input  logic [64*NREQ-1:0]   req_a,
    input  logic [64*NREQ-1:0]   req_b,
    output logic [3:0]           alu_op,
    output logic [63:0]          alu_a,
    output logic [63:0]          alu_b,
    input  logic [63:0]          alu_result,
    input  logic                 alu_zero,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [63:0]          rsp_result,
    output logic                 rsp_zero,
    output logic                 rsp_err
);

    localparam int unsigned PW     = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CW     = $clog2(RSP_DEPTH + 1);
    localparam logic [3:0]  OP_MAX = 4'hA;

    typedef struct packed {
        logic           vld;
        logic           err;
        logic [IDW-1:0] id;
    } tag_t;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [63:0]    result;
        logic           zero;
        logic           err;
    } rsp_t;

    logic [IDW-1:0]  rr_ptr;
    logic [CW-1:0]   credits_used;
    logic [CW-1:0]   count;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    tag_t            tags [ALU_LAT];
    rsp_t            fifo [RSP_DEPTH];

    logic [3:0]      op_arr_c [NREQ];
    logic [63:0]     a_arr_c  [NREQ];
    logic [63:0]     b_arr_c  [NREQ];
    logic [NREQ-1:0] rr_cand_c;
    logic [IDW-1:0]  scan_idx_c;
    logic [IDW-1:0]  grant_id_c;
    logic            grant_vld_c;
    logic            grant_prio_c;
    logic            credit_ok_c;
    logic            g_illegal_c;
    logic            push_c;
    logic            pop_c;
    rsp_t            push_data_c;
    rsp_t            head_c;

    // Unpack the flat request buses into per-requester views
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            op_arr_c[i] = req_op[4*i +: 4];
            a_arr_c[i]  = req_a[64*i +: 64];
            b_arr_c[i]  = req_b[64*i +: 64];
        end
    end

    // Round-robin search from rr_ptr; requester 0 may be pulled out for strict priority
    always_comb begin
        credit_ok_c  = (credits_used < CW'(RSP_DEPTH));
        rr_cand_c    = req_valid;
        scan_idx_c   = '0;
        grant_vld_c  = 1'b0;
        grant_id_c   = '0;
        grant_prio_c = 1'b0;
        req_ready    = '0;
`ifdef ALU_ARB_PRIO0_EN
        rr_cand_c[0] = 1'b0;
`endif
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx_c = IDW'((32'(rr_ptr) + k) % NREQ);
            if (!grant_vld_c && rr_cand_c[scan_idx_c]) begin
                grant_vld_c = 1'b1;
                grant_id_c  = scan_idx_c;
            end
        end
`ifdef ALU_ARB_PRIO0_EN
        if (req_valid[0]) begin
            grant_vld_c  = 1'b1;
            grant_id_c   = '0;
            grant_prio_c = 1'b1;
        end
`endif
        if (!credit_ok_c || reset) begin
            grant_vld_c = 1'b0;
        end
        if (grant_vld_c) begin
            req_ready[grant_id_c] = 1'b1;
        end
    end

    assign g_illegal_c = (op_arr_c[grant_id_c] > OP_MAX);

    // Pointer rotation and ALU operand register; illegal ops leave the ALU bus untouched
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
            alu_op <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
        end else if (grant_vld_c) begin
            if (!grant_prio_c) begin
                rr_ptr <= (grant_id_c == IDW'(NREQ - 1)) ? '0 : IDW'(grant_id_c + 1'b1);
            end
            if (!g_illegal_c) begin
                alu_op <= op_arr_c[grant_id_c];
                alu_a  <= a_arr_c[grant_id_c];
                alu_b  <= b_arr_c[grant_id_c];
            end
        end
    end

    // Tag pipeline aligned with the ALU latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned s = 0; s < ALU_LAT; s++) begin
                tags[s] <= '0;
            end
        end else begin
            tags[0] <= '{vld: grant_vld_c, err: g_illegal_c, id: grant_id_c};
            for (int unsigned s = 1; s < ALU_LAT; s++) begin
                tags[s] <= tags[s-1];
            end
        end
    end

    always_comb begin
        push_c             = tags[ALU_LAT-1].vld;
        push_data_c.id     = tags[ALU_LAT-1].id;
        push_data_c.err    = tags[ALU_LAT-1].err;
        push_data_c.result = tags[ALU_LAT-1].err ? 64'd0 : alu_result;
        push_data_c.zero   = tags[ALU_LAT-1].err ? 1'b1 : alu_zero;
        pop_c              = (count != '0) && rsp_ready;
    end

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : PW'(p + 1'b1);
    endfunction

    // Response FIFO plus credit counter (in flight + queued)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            credits_used <= '0;
            for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
                fifo[i] <= '0;
            end
        end else begin
            if (push_c) begin
                fifo[wr_ptr] <= push_data_c;
                wr_ptr       <= ptr_inc(wr_ptr);
            end
            if (pop_c) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push_c, pop_c})
                2'b10:   count <= CW'(count + 1'b1);
                2'b01:   count <= CW'(count - 1'b1);
                default: count <= count;
            endcase
            case ({grant_vld_c, pop_c})
                2'b10:   credits_used <= CW'(credits_used + 1'b1);
                2'b01:   credits_used <= CW'(credits_used - 1'b1);
                default: credits_used <= credits_used;
            endcase
        end
    end

    assign head_c     = fifo[rd_ptr];
    assign rsp_valid  = (count != '0);
    assign rsp_id     = head_c.id;
    assign rsp_result = head_c.result;
    assign rsp_zero   = head_c.zero;
    assign rsp_err    = head_c.err;

endmodule
